// File: rtl/bit_pkg.sv
// ----------------------------------------------------------------------------
// bit_pkg
// Shared definitions for the iterative carry-less multiply unit (Zbc).
//   - op encodings for clmul / clmulh / clmulr (op 3 is reserved, result 0)
//   - FSM state type shared by the unit and anything observing its debug port
//   - helper computing the iteration count N = XLEN / BITS_PER_CYCLE
// ----------------------------------------------------------------------------
package bit_pkg;

  localparam logic [1:0] BIT_CLMUL  = 2'd0;
  localparam logic [1:0] BIT_CLMULH = 2'd1;
  localparam logic [1:0] BIT_CLMULR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bit_state_e;

  // Number of BUSY iterations needed to consume the whole multiplier.
  function automatic int bit_clmul_iters(input int xlen, input int bits_per_cycle);
    return xlen / bits_per_cycle;
  endfunction

endpackage

// File: rtl/bit_clmul_step.sv
// ----------------------------------------------------------------------------
// bit_clmul_step
// One combinational iteration of the carry-less multiply: for every bit j of
// the current multiplier slice that is set, XOR (rs1_shifted << j) into the
// accumulator. No carries anywhere; all widths are 2*XLEN.
//
// Ports:
//   acc_i   [2*XLEN-1:0]      accumulator before this iteration
//   rs1_i   [2*XLEN-1:0]      multiplicand, already aligned for this slice
//   bits_i  [BITS_PER_CYCLE-1:0] low multiplier bits for this slice
//   acc_o   [2*XLEN-1:0]      accumulator after this iteration
// ----------------------------------------------------------------------------
module bit_clmul_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [2*XLEN-1:0]         acc_i,
  input  logic [2*XLEN-1:0]         rs1_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [2*XLEN-1:0]         acc_o
);

  logic [2*XLEN-1:0] acc;

  always_comb begin
    acc = acc_i;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (bits_i[j]) begin
        acc = acc ^ (rs1_i << j);
      end
    end
  end

  assign acc_o = acc;

endmodule

// File: rtl/bit_clmul_unit.sv
// ----------------------------------------------------------------------------
// bit_clmul_unit
// Iterative carry-less multiplier for clmul / clmulh / clmulr, consuming
// BITS_PER_CYCLE multiplier bits per clock. Sits beside the single-cycle
// bit-manipulation functions in the execute stage.
//
// Handshake: a request is accepted on a rising edge where bit_valid and
// bit_ready are both high; bit_ready is high only in IDLE, and requests
// presented while it is low are dropped (no queuing). Completion is a single
// cycle bit_result_valid pulse; bit_result holds until the next completion.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   bit_valid / ready   request handshake
//   bit_op              0=clmul 1=clmulh 2=clmulr 3=reserved (result 0)
//   bit_rs1 / bit_rs2   multiplicand / multiplier
//   bit_flush           abandon the operation in flight (BUSY or DONE)
//   bit_result          registered result
//   bit_result_valid    one-cycle completion pulse
//   bit_state_dbg       current FSM state, for observation only
//
// Optional feature: define BIT_CLMUL_EARLY_EN to finish as soon as the
// remaining multiplier bits are all zero instead of always running N steps.
// ----------------------------------------------------------------------------
module bit_clmul_unit
  import bit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic [1:0]       bit_op,
  input  logic [XLEN-1:0]  bit_rs1,
  input  logic [XLEN-1:0]  bit_rs2,
  input  logic             bit_flush,
  output logic [XLEN-1:0]  bit_result,
  output logic             bit_result_valid,
  output bit_state_e       bit_state_dbg
);

  localparam int N     = bit_clmul_iters(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  bit_state_e          state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [2*XLEN-1:0]   step_acc;
  logic [XLEN-1:0]     rs2_next;
  logic [XLEN-1:0]     sel_result;
  logic                last_step;

  bit_clmul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .rs1_i  (rs1_q),
    .bits_i (rs2_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (step_acc)
  );

  assign rs2_next = rs2_q >> BITS_PER_CYCLE;

`ifdef BIT_CLMUL_EARLY_EN
  // Once no multiplier bits remain, further steps cannot change the product.
  assign last_step = (cnt_q == CNT_W'(N - 1)) || (rs2_next == '0);
`else
  assign last_step = (cnt_q == CNT_W'(N - 1));
`endif

  // Result selection from the product produced by the final step.
  always_comb begin
    sel_result = '0;
    case (op_q)
      BIT_CLMUL:  sel_result = step_acc[XLEN-1:0];
      BIT_CLMULH: sel_result = step_acc[2*XLEN-1:XLEN];
      BIT_CLMULR: sel_result = step_acc[2*XLEN-2:XLEN-1];
      default:    sel_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        // Flush is meaningless here and must not block an accept.
        if (bit_valid) begin
          state_d = BUSY;
          acc_d   = '0;
          rs1_d   = {{XLEN{1'b0}}, bit_rs1};
          rs2_d   = bit_rs2;
          op_d    = bit_op;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = step_acc;
        rs1_d = rs1_q << BITS_PER_CYCLE;
        rs2_d = rs2_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_flush) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d  = DONE;
          result_d = sel_result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bit_ready        = (state_q == IDLE);
  // A flush (or reset) during DONE suppresses the pulse in that same cycle.
  assign bit_result_valid = (state_q == DONE) && !bit_flush && !reset;
  assign bit_result       = result_q;
  assign bit_state_dbg    = state_q;

endmodule

// File: tb/tb_bit_clmul_unit.sv
// ----------------------------------------------------------------------------
// tb_bit_clmul_unit
// Self-checking bench for bit_clmul_unit: a 32-bit / 4-bits-per-cycle instance
// for directed and random work, plus a 64-bit / 8-bits-per-cycle instance for
// a random sweep. Expected results come from a whole-product reference model.
// ----------------------------------------------------------------------------
module tb_bit_clmul_unit;
  import bit_pkg::*;

  localparam int XLEN = 32;
  localparam int BPC  = 4;
  localparam int N    = XLEN / BPC;
  localparam int WX   = 64;
  localparam int WB   = 8;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 32-bit DUT
  logic            bit_valid, bit_ready, bit_flush, bit_result_valid;
  logic [1:0]      bit_op;
  logic [XLEN-1:0] bit_rs1, bit_rs2, bit_result;
  bit_state_e      bit_state_dbg;

  // 64-bit DUT
  logic          w_valid, w_ready, w_flush, w_result_valid;
  logic [1:0]    w_op;
  logic [WX-1:0] w_rs1, w_rs2, w_result;
  bit_state_e    w_state_dbg;

  bit_clmul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_op(bit_op), .bit_rs1(bit_rs1), .bit_rs2(bit_rs2), .bit_flush(bit_flush),
    .bit_result(bit_result), .bit_result_valid(bit_result_valid),
    .bit_state_dbg(bit_state_dbg)
  );

  bit_clmul_unit #(.XLEN(WX), .BITS_PER_CYCLE(WB)) dut_w (
    .clock(clock), .reset(reset), .bit_valid(w_valid), .bit_ready(w_ready),
    .bit_op(w_op), .bit_rs1(w_rs1), .bit_rs2(w_rs2), .bit_flush(w_flush),
    .bit_result(w_result), .bit_result_valid(w_result_valid),
    .bit_state_dbg(w_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Full 2*xlen carry-less product, then the Zbc result selection.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                             input logic [63:0] b, input int xlen);
    logic [127:0] p;
    logic [127:0] mask;
    p = '0;
    for (int i = 0; i < xlen; i++)
      if (b[i]) p = p ^ ({64'b0, a} << i);
    mask = (128'd1 << xlen) - 128'd1;
    case (op)
      2'd0:    return 64'(p & mask);
      2'd1:    return 64'((p >> xlen) & mask);
      2'd2:    return 64'((p >> (xlen - 1)) & mask);
      default: return 64'd0;
    endcase
  endfunction

  // Edges from accept to the result pulse.
  function automatic int exp_lat(input logic [63:0] b, input int xlen, input int bpc);
`ifdef BIT_CLMUL_EARLY_EN
    int msb;
    int lat;
    msb = -1;
    for (int i = 0; i < xlen; i++) if (b[i]) msb = i;
    lat = (msb + 1 + bpc - 1) / bpc;
    return (lat < 1) ? 1 : lat;
`else
    return xlen / bpc;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int lat;
    int ready_bad;
    bit got;
    @(negedge clock);
    check({tag, "_ready_idle"}, bit_ready, 1);
    bit_valid = 1'b1; bit_op = op; bit_rs1 = a; bit_rs2 = b;
    exp_q.push_back({32'b0, exp});
    @(posedge clock); #1;
    bit_valid = 1'b0; bit_rs1 = $urandom; bit_rs2 = $urandom; bit_op = 2'($urandom);
    lat = 0; got = 1'b0; ready_bad = 0;
    while (!got && lat < 100) begin
      if (bit_ready) ready_bad++;
      @(posedge clock); #1;
      lat++;
      if (bit_result_valid) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat({32'b0, b}, XLEN, BPC)));
      check({tag, "_result"}, {32'b0, bit_result}, exp_q.pop_front());
      check({tag, "_ready_low"}, 64'(ready_bad + int'(bit_ready)), 0);
      last_exp = {32'b0, exp};
      @(posedge clock); #1;
      check({tag, "_pulse_once"}, bit_result_valid, 0);
    end
  endtask

  task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int lat;
    bit got;
    @(negedge clock);
    check("w_ready_idle", w_ready, 1);
    w_valid = 1'b1; w_op = op; w_rs1 = a; w_rs2 = b;
    exp_q.push_back(ref_result(op, a, b, WX));
    @(posedge clock); #1;
    w_valid = 1'b0; w_rs1 = {$urandom, $urandom};
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (w_result_valid) got = 1'b1;
    end
    if (!got) begin
      check("w_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      check("w_latency", 64'(lat), 64'(exp_lat(b, WX, WB)));
      check("w_result", w_result, exp_q.pop_front());
      @(posedge clock); #1;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hits;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] wa, wb;

    vecs[0] = '{2'd0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005};
    vecs[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555};
    vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555};
    vecs[6] = '{2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    vecs[7] = '{2'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF};
    vecs[8] = '{2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    bit_valid = 1'b0; bit_flush = 1'b0; bit_op = '0; bit_rs1 = '0; bit_rs2 = '0;
    w_valid = 1'b0; w_flush = 1'b0; w_op = '0; w_rs1 = '0; w_rs2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", bit_result, 0);
    check("rst_valid", bit_result_valid, 0);
    check("rst_ready", bit_ready, 1);
    check("rst_state", bit_state_dbg, IDLE);
    @(negedge clock);
    reset = 1'b0;
    last_exp = '0;

    // table
    for (int i = 0; i < 9; i++)
      run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // bit_valid held high with fresh operands: one accept per N+2 cycles
    for (int cyc = 0; cyc < 3 * (N + 2); cyc++) begin
      @(negedge clock);
      bit_valid = 1'b1;
      bit_op  = 2'($urandom_range(0, 2));
      bit_rs1 = $urandom;
      bit_rs2 = $urandom | 32'h8000_0000;
      check("hold_ready", bit_ready, (cyc % (N + 2)) == 0);
      if (bit_ready) exp_q.push_back(ref_result(bit_op, {32'b0, bit_rs1}, {32'b0, bit_rs2}, XLEN));
      @(posedge clock); #1;
      check("hold_valid", bit_result_valid, (cyc % (N + 2)) == N);
      if (bit_result_valid && exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        check("hold_result", {32'b0, bit_result}, last_exp);
      end
    end
    bit_valid = 1'b0;
    check("hold_drained", 64'(exp_q.size()), 0);

    // flush in BUSY, three edges after accept
    @(negedge clock);
    bit_valid = 1'b1; bit_op = 2'd0; bit_rs1 = 32'h1234_5678; bit_rs2 = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bit_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    @(negedge clock);
    bit_flush = 1'b1;
    @(posedge clock); #1;
    bit_flush = 1'b0;
    check("flush_ready", bit_ready, 1);
    check("flush_result_kept", {32'b0, bit_result}, last_exp);
    hits = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clock); #1;
      if (bit_result_valid) hits++;
    end
    check("flush_no_pulse", 64'(hits), 0);
    check("flush_result_after", {32'b0, bit_result}, last_exp);
    run32(2'd0, 32'h0000_00FF, 32'h0000_0101, 32'h0000_FFFF, "after_flush");

    // flush during DONE suppresses the pulse but the result is already latched
    @(negedge clock);
    bit_valid = 1'b1; bit_op = 2'd1; bit_rs1 = 32'hFFFF_FFFF; bit_rs2 = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bit_valid = 1'b0;
    hits = 0;
    while (!bit_result_valid && hits < 100) begin @(posedge clock); #1; hits++; end
    check("done_flush_lat", 64'(hits), 64'(exp_lat(64'hFFFF_FFFF, XLEN, BPC)));
    bit_flush = 1'b1; #1;
    check("done_flush_valid", bit_result_valid, 0);
    check("done_flush_result", bit_result, 32'h5555_5555);
    @(posedge clock); #1;
    bit_flush = 1'b0;
    check("done_flush_idle", bit_ready, 1);
    last_exp = 64'h5555_5555;

    // flush in IDLE does not block an accept
    @(negedge clock);
    bit_flush = 1'b1; bit_valid = 1'b1; bit_op = 2'd0; bit_rs1 = 32'h0000_0007; bit_rs2 = 32'h8000_0003;
    @(posedge clock); #1;
    bit_flush = 1'b0; bit_valid = 1'b0;
    check("idle_flush_accept", bit_state_dbg, BUSY);
    hits = 0;
    while (!bit_result_valid && hits < 100) begin @(posedge clock); #1; hits++; end
    check("idle_flush_result", {32'b0, bit_result},
          ref_result(2'd0, 64'h7, 64'h8000_0003, XLEN));
    @(posedge clock); #1;

    // reset mid-BUSY
    @(negedge clock);
    bit_valid = 1'b1; bit_op = 2'd0; bit_rs1 = 32'hAAAA_5555; bit_rs2 = 32'hFFFF_0000;
    @(posedge clock); #1;
    bit_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_result", bit_result, 0);
    check("midrst_valid", bit_result_valid, 0);
    check("midrst_ready", bit_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clock); #1;
      if (bit_result_valid) hits++;
    end
    check("midrst_no_pulse", 64'(hits), 0);
    last_exp = '0;

    // random sweep, 32-bit
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      run32(rop, ra, rb, 32'(ref_result(rop, {32'b0, ra}, {32'b0, rb}, XLEN)), "rand32");
    end

    // random sweep, 64-bit
    for (int i = 0; i < 20; i++) begin
      wa = {$urandom, $urandom};
      wb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run64(2'($urandom_range(0, 3)), wa, wb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_clmul_unit.md
Name: bit_clmul_unit

Overview:
- Iterative, parametrised carry-less multiply unit for the RISC-V Zbc extension: clmul, clmulh, clmulr.
- Sits beside the single-cycle bit-manipulation functions in the execute stage.
- Processes BITS_PER_CYCLE multiplier bits per clock.
- Uses a valid/ready request handshake and returns a one-cycle result pulse.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
BITS_PER_CYCLE, 4, multiplier bits consumed per iteration; must divide XLEN; iterations N = XLEN/BITS_PER_CYCLE.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
bit_valid  in  1  request strobe.
bit_ready  out  1  unit can accept; high only in IDLE.
bit_op  in  2  0=clmul, 1=clmulh, 2=clmulr, 3=reserved.
bit_rs1  in  XLEN  multiplicand.
bit_rs2  in  XLEN  multiplier.
bit_flush  in  1  abandon operation in flight.
bit_result  out  XLEN  result, held until the next completion.
bit_result_valid  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE, bit_result=0, bit_result_valid=0, accumulator/counter=0; bit_ready=1 in the first cycle after reset.
- Reset mid-operation discards all work; no result_valid is produced.
- States:
  - IDLE: accept on the edge where bit_valid && bit_ready. Latch rs1 zero-extended to 2*XLEN, rs2, and op; clear the 2*XLEN accumulator and counter; go to BUSY.
  - BUSY: each edge XORs (rs1_shifted << j) into the accumulator for every j<BITS_PER_CYCLE where rs2_shifted[j]=1. Then rs1_shifted <<= BITS_PER_CYCLE, rs2_shifted >>= BITS_PER_CYCLE, counter++. On the edge where counter == N-1, go to DONE.
  - DONE: bit_result_valid=1 for exactly this cycle; go to IDLE on the next edge.
- bit_ready is combinational: state==IDLE.
- Requests while not ready are ignored; no queuing.
- Result selection from product P[2*XLEN-1:0], registered on entry to DONE:
  - clmul = P[XLEN-1:0]
  - clmulh = P[2*XLEN-1:XLEN]
  - clmulr = P[2*XLEN-2:XLEN-1]
  - op 3 = 0
- Latency: bit_result_valid is high N edges after the accepting edge (8 for defaults). Throughput is one operation per N+2 cycles.
- bit_flush in BUSY or DONE: state=IDLE on the next edge; bit_result_valid forced low that cycle; bit_result unchanged. bit_flush in IDLE has no effect and does not block a simultaneous accept.
- Flush and reset together: reset wins.
- All arithmetic is XOR-only; no carries; accumulator width exactly 2*XLEN.

Optional Feature:
- Macro BIT_CLMUL_EARLY_EN.
- Defined: in BUSY, if the post-shift rs2_shifted == 0, go to DONE on that edge regardless of the counter. Latency becomes ceil((msb_index(rs2)+1)/BITS_PER_CYCLE), minimum 1. rs2=0 completes 1 edge after acceptance with result 0.
- Undefined: latency is always N; the zero-detect logic is absent.

Decomposition:
- Shared package bit_pkg holds:
  - op encoding constants BIT_CLMUL=0, BIT_CLMULH=1, BIT_CLMULR=2
  - state typedef {IDLE,BUSY,DONE}
  - localparam helper for N
- One combinational sub-module bit_clmul_step: inputs accumulator, rs1_shifted, BITS_PER_CYCLE low bits of rs2_shifted; output next accumulator.
- bit_clmul_unit instantiates bit_clmul_step once and owns the FSM, counter and result mux.

Test Plan:
- clmul rs1=0x00000003, rs2=0x00000003 -> bit_result=0x00000005 with bit_result_valid 8 edges after accept; bit_ready=0 throughout.
- rs1=rs2=0x80000000 with op=1 -> 0x40000000; same operands with op=2 -> 0x80000000; op=0 -> 0x00000000.
- bit_valid held high continuously with new operands -> only one accept per N+2 cycles. Requests during BUSY/DONE are ignored; results match the accepted operands.
- bit_flush asserted 3 edges after accept -> IDLE next edge. No result_valid; bit_result keeps the previous value; a new request is accepted immediately after.
- reset asserted mid-BUSY -> bit_result=0, bit_result_valid=0, bit_ready=1 next cycle.
- With BIT_CLMUL_EARLY_EN: rs2=0x00000001 -> valid 1 edge after accept; rs2=0 -> result 0 after 1 edge. Without the macro, both take 8 edges. Random op/operand sweep versus a software reference model for XLEN=32 and 64 and BITS_PER_CYCLE in {1, 4, 8}.
